// File: rtl/div64.sv
`default_nettype none
// ============================================================================
// Module   : div64
// Purpose  : Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU.
//            Produces one quotient bit per clock. Operands arrive on a
//            valid/ready handshake and results leave on another.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, dividend, divisor, sign  -- operand side
//            flush                                       -- abort in flight
//            out_valid/out_ready, quotient, remainder    -- result side
// Revision : 1.0  initial release
// ============================================================================
module div64 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            sign,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int        CW     = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;     // partial remainder, always < |y| between steps
  logic [XLEN-1:0] r_quo;     // holds |x| on entry, shifts into the quotient
  logic [XLEN-1:0] r_div;     // |y|
  logic            r_xneg;    // signed op with negative dividend
  logic            r_yneg;    // signed op with negative divisor
  logic            r_div0;
  logic            r_ovf;

  logic [XLEN-1:0] w_xmag;
  logic [XLEN-1:0] w_ymag;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_xorig;
  logic            w_special;
  logic            w_last;

  assign w_xmag = (sign && dividend[XLEN-1]) ? -dividend : dividend;
  assign w_ymag = (sign && divisor[XLEN-1])  ? -divisor  : divisor;

  // One restoring step. The shifted remainder needs XLEN+1 bits for the
  // compare; after a subtract the result is below |y|, so the low XLEN bits
  // of a modular subtraction are exact.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[XLEN-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

  // Original dividend, rebuilt from magnitude and sign (-2^63 round-trips).
  assign w_xorig   = r_xneg ? -r_quo : r_quo;
  assign w_special = r_div0 || r_ovf;
  assign w_last    = (r_cnt == C_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = S_CALC;
      S_CALC: begin
        if (flush)                    w_state_nxt = S_IDLE;
        else if (w_special || w_last) w_state_nxt = S_DONE;
      end
      S_DONE: if (flush || out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_xneg    <= 1'b0;
      r_yneg    <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= w_xmag;
            r_div  <= w_ymag;
            r_xneg <= sign & dividend[XLEN-1];
            r_yneg <= sign & divisor[XLEN-1];
            r_div0 <= (divisor == '0);
            r_ovf  <= sign && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                           && (divisor == '1);
          end
        end
        S_CALC: begin
          if (!flush) begin
            if (r_div0) begin
              quotient  <= '1;
              remainder <= w_xorig;
            end else if (r_ovf) begin
              quotient  <= w_xorig;
              remainder <= '0;
            end else begin
              r_rem <= w_rem_nxt;
              r_quo <= w_quo_nxt;
              r_cnt <= r_cnt + 1'b1;
              if (w_last) begin
                quotient  <= (r_xneg ^ r_yneg) ? -w_quo_nxt : w_quo_nxt;
                remainder <= r_xneg ? -w_rem_nxt : w_rem_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div64.sv
`default_nettype none
// ============================================================================
// Module   : tb_div64
// Purpose  : Self-checking bench for div64 with an expected-result queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_div64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        sign = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;
  exp_t sb[$];

  div64 #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .sign(sign),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand set, return just after the accepting edge.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic s,
                      input logic [63:0] eq, input logic [63:0] er, input int lat);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    dividend = x; divisor = y; sign = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = {$urandom(), $urandom()};
    divisor  = {$urandom(), $urandom()};
    sign     = 1'($urandom_range(0, 1));
    sb.push_back('{q: eq, r: er, lat: lat});
  endtask

  // Wait for the result, check latency and values, optionally stall, then take it.
  task automatic recv(input string tag, input int hold);
    exp_t e;
    int   edges = 0;
    logic [63:0] q0, r0;
    while (!out_valid && edges < 200) begin tick(); edges++; end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(edges), 64'(e.lat));
    chk({tag, "_q"}, quotient, e.q);
    chk({tag, "_r"}, remainder, e.r);
    q0 = quotient; r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_q"}, quotient, q0);
      chk({tag, "_hold_r"}, remainder, r0);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_taken_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_taken_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic signed [63:0] xs, ys;
    logic [63:0] xu, yu;
    logic        s;
    exp_t        drop;

    // Reset state.
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed vectors.
    send(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64);
    recv("u100_7", 0);
    send(-64'sd7, 64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    recv("sm7_2", 0);
    send(64'sd7, -64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64);
    recv("s7_m2", 0);
    send(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    recv("u_div0", 0);
    send(64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
    recv("s_div0", 0);
    send(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
         64'h8000_0000_0000_0000, 64'd0, 1);
    recv("s_ovf", 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64);
    recv("u_max_1", 0);

    // Backpressure: -100/7 signed -> q=-14, r=-2, held 10 cycles.
    send(-64'sd100, 64'sd7, 1'b1, -64'sd14, -64'sd2, 64);
    recv("bp_sm100_7", 10);

    // Random vectors against the language's own division.
    for (int k = 0; k < 4; k++) begin
      xu = {$urandom(), $urandom()};
      yu = {$urandom(), $urandom()} >> $urandom_range(0, 60);
      if (yu == 64'd0) yu = 64'd3;
      s  = 1'(k & 1);
      if (s) begin
        xs = $signed(xu); ys = $signed(yu);
        send(xu, yu, 1'b1, 64'(xs / ys), 64'(xs % ys), 64);
      end else begin
        send(xu, yu, 1'b0, xu / yu, xu % yu, 64);
      end
      recv("rand", 0);
    end

    // Async reset at iteration 30.
    send(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64);
    repeat (30) tick();
    chk("abort_busy", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst_in_ready", 64'(in_ready), 64'd1);
    chk("abort_rst_out_valid", 64'(out_valid), 64'd0);
    chk("abort_rst_q", quotient, 64'd0);
    chk("abort_rst_r", remainder, 64'd0);
    if (sb.size() > 0) drop = sb.pop_front();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Flush at iteration 30, then a clean divide.
    send(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64);
    repeat (30) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    if (sb.size() > 0) drop = sb.pop_front();
    repeat (40) tick();
    chk("flush_no_result", 64'(out_valid), 64'd0);
    send(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 64);
    recv("post_flush_100_7", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
